// File: rtl/p2p_pkt_gen_250mhz.sv
// p2p_pkt_gen_250mhz
// AXI4-Stream packet generator with a 512-bit data path. A run sends num_pkts
// packets (or runs until stop when num_pkts is 0), separated by ifg_cycles idle
// cycles. Byte i of packet n carries (n+i) mod 256.
// Optional feature macro: P2P_PKT_GEN_STATS_EN adds per-run packet and byte
// statistics outputs (stat_pkt_cnt, stat_byte_cnt).
module p2p_pkt_gen_250mhz #(
    parameter int MAX_PKT_BYTES = 9600
) (
    input  logic          axis_aclk,
    input  logic          mod_rstn,
    input  logic          start,
    input  logic          stop,
    input  logic [31:0]   num_pkts,
    input  logic [15:0]   pkt_size,
    input  logic [15:0]   cfg_src,
    input  logic [15:0]   cfg_dst,
    input  logic [7:0]    ifg_cycles,
    output logic          busy,
    output logic          done,
    output logic          m_axis_tvalid,
    output logic [511:0]  m_axis_tdata,
    output logic [63:0]   m_axis_tkeep,
    output logic          m_axis_tlast,
    output logic [15:0]   m_axis_tuser_size,
    output logic [15:0]   m_axis_tuser_src,
    output logic [15:0]   m_axis_tuser_dst,
    input  logic          m_axis_tready
`ifdef P2P_PKT_GEN_STATS_EN
    ,
    output logic [31:0]   stat_pkt_cnt,
    output logic [47:0]   stat_byte_cnt
`endif
);

    localparam logic [15:0] MIN_SIZE = 16'd64;
    localparam logic [15:0] MAX_SIZE = 16'(MAX_PKT_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t        state;
    state_t        state_next;

    // Configuration captured when a run is accepted
    logic [31:0]   lat_num;
    logic [15:0]   lat_size;
    logic [15:0]   lat_src;
    logic [15:0]   lat_dst;
    logic [7:0]    lat_ifg;

    // Run progress
    logic [31:0]   pkt_idx;
    logic [31:0]   pkt_next;
    logic [31:0]   pkt_inc;
    logic [10:0]   beat_idx;
    logic [10:0]   beat_next;
    logic [7:0]    gap_cnt;
    logic [7:0]    gap_next;
    logic          stop_pend;
    logic          stop_pend_next;
    logic          done_next;

    // Control strobes from the FSM
    logic          latch;
    logic          load;
    logic          drop;
    logic          xfer;
    logic          count_reached;

    // Description of the beat about to be placed on the bus
    logic [7:0]    ld_seed;
    logic [10:0]   ld_beat;
    logic [15:0]   size_clamped;
    logic [15:0]   ld_size;
    logic [15:0]   ld_src;
    logic [15:0]   ld_dst;
    logic [16:0]   ld_sum;
    logic [10:0]   ld_nbeats;
    logic          ld_last;
    logic [63:0]   ld_keep;
    logic [511:0]  ld_data;

    assign xfer          = m_axis_tvalid & m_axis_tready;
    assign pkt_inc       = pkt_idx + 32'd1;
    assign count_reached = (lat_num != 32'd0) && (pkt_inc == lat_num);
    assign busy          = (state != ST_IDLE);

    // Clamp the requested packet size into the legal range
    always_comb begin
        size_clamped = pkt_size;
        if (pkt_size < MIN_SIZE) begin
            size_clamped = MIN_SIZE;
        end else if (pkt_size > MAX_SIZE) begin
            size_clamped = MAX_SIZE;
        end
    end

    // In IDLE the run is being accepted this cycle, so use the live inputs
    always_comb begin
        ld_size = lat_size;
        ld_src  = lat_src;
        ld_dst  = lat_dst;
        if (state == ST_IDLE) begin
            ld_size = size_clamped;
            ld_src  = cfg_src;
            ld_dst  = cfg_dst;
        end
    end

    // Build keep mask and payload for the beat selected by ld_seed/ld_beat
    always_comb begin
        ld_sum    = {1'b0, ld_size} + 17'd63;
        ld_nbeats = ld_sum[16:6];
        ld_last   = (ld_beat == (ld_nbeats - 11'd1));
        ld_keep   = {64{1'b1}};
        if (ld_last && (ld_size[5:0] != 6'd0)) begin
            ld_keep = (64'd1 << ld_size[5:0]) - 64'd1;
        end
        ld_data = '0;
        for (int k = 0; k < 64; k++) begin
            if (ld_keep[k]) begin
                ld_data[8*k +: 8] = ld_seed + {ld_beat[1:0], 6'd0} + 8'(k);
            end
        end
    end

    // Next-state and control decode
    always_comb begin
        state_next     = state;
        latch          = 1'b0;
        load           = 1'b0;
        drop           = 1'b0;
        done_next      = 1'b0;
        pkt_next       = pkt_idx;
        beat_next      = beat_idx;
        gap_next       = gap_cnt;
        stop_pend_next = stop_pend;
        ld_seed        = pkt_idx[7:0];
        ld_beat        = beat_idx;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next     = ST_SEND;
                    latch          = 1'b1;
                    load           = 1'b1;
                    pkt_next       = 32'd0;
                    beat_next      = 11'd0;
                    gap_next       = 8'd0;
                    stop_pend_next = 1'b0;
                    ld_seed        = 8'd0;
                    ld_beat        = 11'd0;
                end
            end
            ST_SEND: begin
                if (stop) begin
                    stop_pend_next = 1'b1;
                end
                if (xfer) begin
                    if (m_axis_tlast) begin
                        if (stop_pend || stop || count_reached) begin
                            state_next     = ST_IDLE;
                            drop           = 1'b1;
                            done_next      = 1'b1;
                            stop_pend_next = 1'b0;
                        end else begin
                            pkt_next  = pkt_inc;
                            beat_next = 11'd0;
                            if (lat_ifg == 8'd0) begin
                                load    = 1'b1;
                                ld_seed = pkt_inc[7:0];
                                ld_beat = 11'd0;
                            end else begin
                                state_next = ST_GAP;
                                drop       = 1'b1;
                                gap_next   = 8'd0;
                            end
                        end
                    end else begin
                        beat_next = beat_idx + 11'd1;
                        load      = 1'b1;
                        ld_beat   = beat_idx + 11'd1;
                    end
                end
            end
            ST_GAP: begin
                if (stop_pend || stop) begin
                    state_next     = ST_IDLE;
                    done_next      = 1'b1;
                    stop_pend_next = 1'b0;
                end else if (gap_cnt == (lat_ifg - 8'd1)) begin
                    state_next = ST_SEND;
                    load       = 1'b1;
                    ld_seed    = pkt_idx[7:0];
                    ld_beat    = 11'd0;
                end else begin
                    gap_next = gap_cnt + 8'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge axis_aclk) begin
        if (!mod_rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Run counters, pending stop, done pulse and captured configuration
    always_ff @(posedge axis_aclk) begin
        if (!mod_rstn) begin
            pkt_idx   <= 32'd0;
            beat_idx  <= 11'd0;
            gap_cnt   <= 8'd0;
            stop_pend <= 1'b0;
            done      <= 1'b0;
            lat_num   <= 32'd0;
            lat_size  <= 16'd0;
            lat_src   <= 16'd0;
            lat_dst   <= 16'd0;
            lat_ifg   <= 8'd0;
        end else begin
            pkt_idx   <= pkt_next;
            beat_idx  <= beat_next;
            gap_cnt   <= gap_next;
            stop_pend <= stop_pend_next;
            done      <= done_next;
            if (latch) begin
                lat_num  <= num_pkts;
                lat_size <= size_clamped;
                lat_src  <= cfg_src;
                lat_dst  <= cfg_dst;
                lat_ifg  <= ifg_cycles;
            end
        end
    end

    // Output beat register; only reloaded on acceptance so a stalled beat holds
    always_ff @(posedge axis_aclk) begin
        if (!mod_rstn) begin
            m_axis_tvalid     <= 1'b0;
            m_axis_tdata      <= '0;
            m_axis_tkeep      <= '0;
            m_axis_tlast      <= 1'b0;
            m_axis_tuser_size <= 16'd0;
            m_axis_tuser_src  <= 16'd0;
            m_axis_tuser_dst  <= 16'd0;
        end else if (load) begin
            m_axis_tvalid     <= 1'b1;
            m_axis_tdata      <= ld_data;
            m_axis_tkeep      <= ld_keep;
            m_axis_tlast      <= ld_last;
            m_axis_tuser_size <= ld_size;
            m_axis_tuser_src  <= ld_src;
            m_axis_tuser_dst  <= ld_dst;
        end else if (drop) begin
            m_axis_tvalid     <= 1'b0;
            m_axis_tdata      <= '0;
            m_axis_tkeep      <= '0;
            m_axis_tlast      <= 1'b0;
        end
    end

`ifdef P2P_PKT_GEN_STATS_EN
    // Per-run statistics, cleared when a run starts and bumped per packet
    always_ff @(posedge axis_aclk) begin
        if (!mod_rstn) begin
            stat_pkt_cnt  <= 32'd0;
            stat_byte_cnt <= 48'd0;
        end else if (latch) begin
            stat_pkt_cnt  <= 32'd0;
            stat_byte_cnt <= 48'd0;
        end else if (xfer && m_axis_tlast) begin
            stat_pkt_cnt  <= stat_pkt_cnt + 32'd1;
            stat_byte_cnt <= stat_byte_cnt + 48'(lat_size);
        end
    end
`endif

endmodule

// File: doc/p2p_pkt_gen_250mhz.md
P2P_PKT_GEN_250MHZ -- requirements
Module: p2p_pkt_gen_250mhz

Interface
REQ-001 SHALL have parameter MAX_PKT_BYTES, default 9600, giving the largest packet size in bytes; legal range 64..65535.
REQ-002 SHALL have port axis_aclk  input  1  sole clock; all logic is rising-edge.
REQ-003 SHALL have port mod_rstn  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a run.
REQ-005 SHALL have port stop  input  1  one-cycle request to end a run after the current packet.
REQ-006 SHALL have port num_pkts  input  32  packets per run; 0 means continuous until stop.
REQ-007 SHALL have port pkt_size  input  16  packet length in bytes.
REQ-008 SHALL have port cfg_src / cfg_dst  input  16 each  tuser_src / tuser_dst values.
REQ-009 SHALL have port ifg_cycles  input  8  idle cycles between packets.
REQ-010 SHALL have port busy  output  1  high while not IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse at run end.
REQ-012 SHALL have ports m_axis_tvalid/tdata/tkeep/tlast  output  1/512/64/1  AXI4-Stream master.
REQ-013 SHALL have ports m_axis_tuser_size/tuser_src/tuser_dst  output  16 each  per-packet sideband.
REQ-014 SHALL have port m_axis_tready  input  1  downstream ready.
REQ-015 SHALL have ports stat_pkt_cnt  output  32 and stat_byte_cnt  output  48, present only per REQ-033.

Function
REQ-016 SHALL use three states, IDLE, SEND and GAP; start in IDLE is the only exit from IDLE.
REQ-017 SHALL latch num_pkts, pkt_size, cfg_src, cfg_dst and ifg_cycles on an accepted start, and ignore start while busy.
REQ-018 SHALL clamp the latched size to 64 if pkt_size<64 and to MAX_PKT_BYTES if pkt_size>MAX_PKT_BYTES.
REQ-019 SHALL assert m_axis_tvalid in the cycle after start is sampled in IDLE.
REQ-020 SHALL emit ceil(size/64) beats per packet.
REQ-021 SHALL drive tkeep all-ones on non-last beats; on the last beat the low (size mod 64) bits SHALL be set, or all 64 bits when size mod 64 is 0.
REQ-022 SHALL assert tlast only on the last beat.
REQ-023 SHALL set byte i of packet n (n from 0 within the run, i the byte offset) to (n+i) mod 256; tdata[8k+7:8k] carries byte 64*beat+k, and bytes outside tkeep SHALL be 0.
REQ-024 SHALL hold tuser_size=size, tuser_src and tuser_dst constant across all beats of a packet.
REQ-025 SHALL, once tvalid is high, hold tvalid, tdata, tkeep, tlast and tuser stable until tvalid&tready; a beat advances only on tvalid&tready.
REQ-026 SHALL, after a tlast transfer when more packets remain, go to GAP with tvalid low for exactly ifg_cycles cycles and then return to SEND.
REQ-027 SHALL, with ifg_cycles=0, present the next packet's first beat in the cycle following the tlast transfer.
REQ-028 SHALL register stop when received in SEND or GAP, finish the current packet (from GAP: end immediately), then return to IDLE; stop in IDLE SHALL be ignored.
REQ-029 SHALL pulse done for one cycle on entry to IDLE from a completed or stopped run, and drop busy in that same cycle.
REQ-030 SHALL give stop priority over packet-count completion when both occur together; this produces a single done pulse.

Reset
REQ-031 SHALL, with mod_rstn low at a clock edge, enter IDLE and drive tvalid, tlast, busy and done to 0 and tdata, tkeep, tuser, the counters and the latched config to 0.
REQ-032 SHALL abandon a packet in flight on reset, with no tlast completion and no done pulse.

Configuration
REQ-033 SHALL compile stat_pkt_cnt and stat_byte_cnt only when P2P_PKT_GEN_STATS_EN is defined; these counters are cleared on start, increment on each tlast transfer by 1 and by size respectively, and wrap modulo 2^width; when the macro is undefined the ports and logic SHALL be absent.

Verification
REQ-034 SHALL test pkt_size=64, num_pkts=1, tready=1: expect 1 beat with tkeep=all-ones, tlast=1, tuser_size=64, byte0=0x00, and done one cycle after the transfer.
REQ-035 SHALL test pkt_size=130, num_pkts=2, ifg=0: expect 3 beats per packet, last tkeep=0x3, packet 1 beat 0 byte0=0x01, and no gap between packets.
REQ-036 SHALL test pseudo-random tready with 50% duty and pkt_size=200: expect payload and sideband stable while stalled and all 4 beats delivered in order.
REQ-037 SHALL test ifg_cycles=3, num_pkts=3: expect exactly 3 tvalid-low cycles after each non-final tlast.
REQ-038 SHALL test num_pkts=0 with stop asserted mid-packet 5: expect packet 5 to complete with tlast, then done and busy=0.
REQ-039 SHALL test mod_rstn low during beat 2 of a 9600-byte packet: expect tvalid=0 next cycle, IDLE, no done, and a clean run on a later start.
